fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and load-use hazard controller for the integer pipeline.
//  It keeps its own shadow pipeline of in-flight writers: dest reg, write-enable and is-load,
//  one entry per stage from EX out to FWD_DEPTH.
//  For the instruction in ID it decides whether to stall.
//  It also registers, per source operand, which pipeline latch feeds the ALU when that instruction is in EX.
//  It sits between decode and the EX operand muxes.
// PARAMETERS
//  REG_W     5  register address width
//  NSRC      2  source operands per instruction
//  FWD_DEPTH 2  forwardable latches: distance 1 = EX/MEM ... FWD_DEPTH = last latch before regfile
//  LOAD_LAT  1  extra cycles after EX before load data is forwardable; must be < FWD_DEPTH
//  ZERO_REG  1  1: register 0 is hardwired zero, never matched
//  (SEL_W = $clog2(FWD_DEPTH+1), derived)
// PORTS
//  clk         in   1            clock
//  rst         in   1            synchronous active-high reset
//  id_valid    in   1            ID holds a real instruction
//  id_rd       in   REG_W        ID destination register
//  id_wr       in   1            ID instruction writes id_rd
//  id_load     in   1            ID instruction is a load
//  id_rs       in   NSRC*REG_W   ID source regs, operand i at [i*REG_W +: REG_W]
//  id_rs_used  in   NSRC         operand i actually read
//  flush       in   1            kill ID and all shadow entries (branch redirect)
//  stall       out  1            hold PC and IF/ID this cycle; inject bubble into ID/EX
//  ex_valid    out  1            registered: EX holds a real instruction
//  ex_fwd_sel  out  NSRC*SEL_W   registered per operand: 0 = regfile, d = latch at distance d
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - All shadow entries go invalid; FSM goes to RUN; stall_cnt=0; ex_valid=0; ex_fwd_sel=0.
//   - Reset overrides flush and any stall in progress, including mid-stall.
//  Shadow pipeline sh[0..FWD_DEPTH-1]
//   - sh[0] is the instruction currently in EX.
//   - Each cycle sh[k] <= sh[k-1], k >= 1; this never pauses, downstream has no stalls.
//   - sh[0] <= ID instruction when id_valid & ~stall & ~flush, otherwise a bubble (valid=0).
//  Match rule, per used operand i
//   - An entry matches if valid & wr & rd == rs_i, and not (ZERO_REG & rs_i == 0).
//   - Only the youngest match counts, i.e. smallest k; its distance is d = k+1.
//   - Older matches are ignored, even if they are loads.
//   - No match in the shadow means sel=0; the regfile is write-through, so it holds the value.
//  Load-use hazard, per operand
//   - Hazard when the youngest match is a load with d < 1+LOAD_LAT.
//   - Required wait for that operand: need = 1+LOAD_LAT-d cycles. N = max need over operands.
//  FSM (2 states)
//   - RUN: stall = hazard (combinational, same cycle).
//     On hazard with N>1: go to STALL with stall_cnt = N-1. With N=1 the FSM stays in RUN.
//     The next cycle re-evaluates naturally, because the bubble has shifted the shadow.
//   - STALL: stall = 1 unconditionally; stall_cnt decrements; at stall_cnt==1, next state is RUN.
//   - flush in any state: next state RUN, stall_cnt=0, stall forced 0 this cycle.
//     All sh[] entries are invalidated at the edge.
//  EX outputs (1-cycle latency, registered at the posedge where ID advances)
//   - ex_valid <= id_valid & ~stall & ~flush.
//   - ex_fwd_sel[i] <= youngest-match distance d, or 0 if no match.
//     Also 0 if ~id_rs_used[i], or if the instruction is not advancing (bubble).
//   - A load at d >= 1+LOAD_LAT is forwarded normally with sel = d.
//  Width rules
//   - Distances are 1..FWD_DEPTH and fit SEL_W.
//   - The NSRC operands are evaluated independently in parallel.
//   - Same rd on several operands gives the same sel on each.
// TESTING (defaults: REG_W=5 NSRC=2 FWD_DEPTH=2 LOAD_LAT=1 ZERO_REG=1)
//  - ALU back-to-back:
//    issue add r3 (wr) then add rs0=r3 rs1=r3.
//    Expect stall=0; next cycle ex_fwd_sel={2'd1,2'd1}, ex_valid=1.
//  - Distance 2:
//    add r5, nop, then sub rs0=r5.
//    Expect ex_fwd_sel op0=2 and op1=0 (op1 unused).
//  - Load-use:
//    lw r7, then add rs0=r7.
//    Expect stall=1 for exactly 1 cycle and ex_valid=0 on the bubble.
//    Then ex_fwd_sel op0=2, ex_valid=1.
//  - LOAD_LAT=2 variant with FWD_DEPTH=3:
//    lw r7 then a use. Expect stall for 2 cycles (FSM enters STALL), then op0 sel=3.
//  - Zero reg and priority:
//    add r0 then use rs0=r0. Expect sel 0, no stall.
//    lw r4 followed by add r4, then use r4. Expect sel=1, no stall, youngest wins.
//  - Flush/reset mid-stall (LOAD_LAT=2):
//    assert flush in the first stall cycle. Expect stall=0 that cycle and ex_valid=0 next.
//    The shadow is empty, so a following use of r7 gives sel=0.
//    Repeat with rst: same result, ex_fwd_sel=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the integer pipeline.
// A shadow pipeline of in-flight writers is compared against the ID source registers.
module fwd_hazard_unit #(
    parameter int REG_W     = 5,
    parameter int NSRC      = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_REG  = 1,
    localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_wr,
    input  logic                    id_load,
    input  logic [NSRC*REG_W-1:0]   id_rs,
    input  logic [NSRC-1:0]         id_rs_used,
    input  logic                    flush,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [NSRC*SEL_W-1:0]   ex_fwd_sel,
    output logic                    dbg_state
);

    typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_t;

    // Handshake: ID advances into EX on a clock edge only when id_valid & ~stall & ~flush;
    // otherwise a bubble enters EX. Downstream of EX never stalls.
    state_t                 r_state;
    logic [SEL_W-1:0]       r_stall_cnt;
    logic [FWD_DEPTH-1:0]   r_sh_valid;
    logic [FWD_DEPTH-1:0]   r_sh_wr;
    logic [FWD_DEPTH-1:0]   r_sh_load;
    logic [REG_W-1:0]       r_sh_rd [FWD_DEPTH];
    logic                   r_ex_valid;
    logic [NSRC*SEL_W-1:0]  r_ex_fwd_sel;

    logic [SEL_W-1:0]       w_dist [NSRC];
    logic [SEL_W-1:0]       w_need [NSRC];
    logic [NSRC-1:0]        w_ld;
    logic [SEL_W-1:0]       w_need_max;
    logic                   w_hazard;
    logic                   w_advance;

    // The descending scan lets the youngest (smallest k) match overwrite older ones.
    always_comb begin
        w_hazard   = 1'b0;
        w_need_max = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_dist[i] = '0;
            w_need[i] = '0;
            w_ld[i]   = 1'b0;
            if (id_rs_used[i] && !(ZERO_REG != 0 && id_rs[i*REG_W +: REG_W] == '0)) begin
                for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                    if (r_sh_valid[k] && r_sh_wr[k] && r_sh_rd[k] == id_rs[i*REG_W +: REG_W]) begin
                        w_dist[i] = SEL_W'(k + 1);
                        w_ld[i]   = r_sh_load[k];
                    end
                end
            end
            if (id_valid && w_ld[i] && w_dist[i] < SEL_W'(1 + LOAD_LAT)) begin
                w_hazard  = 1'b1;
                w_need[i] = SEL_W'(1 + LOAD_LAT) - w_dist[i];
                if (w_need[i] > w_need_max) w_need_max = w_need[i];
            end
        end
    end

    assign stall      = !flush && (r_state == S_STALL || w_hazard);
    assign w_advance  = id_valid && !stall && !flush;
    assign ex_valid   = r_ex_valid;
    assign ex_fwd_sel = r_ex_fwd_sel;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_stall_cnt  <= '0;
            r_sh_valid   <= '0;
            r_sh_wr      <= '0;
            r_sh_load    <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) r_sh_rd[k] <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_fwd_sel <= '0;
        end else begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_sh_valid[k] <= flush ? 1'b0 : r_sh_valid[k-1];
                r_sh_wr[k]    <= r_sh_wr[k-1];
                r_sh_load[k]  <= r_sh_load[k-1];
                r_sh_rd[k]    <= r_sh_rd[k-1];
            end
            r_sh_valid[0] <= w_advance;
            r_sh_wr[0]    <= id_wr;
            r_sh_load[0]  <= id_load;
            r_sh_rd[0]    <= id_rd;

            r_ex_valid <= w_advance;
            for (int i = 0; i < NSRC; i++)
                r_ex_fwd_sel[i*SEL_W +: SEL_W] <= w_advance ? w_dist[i] : '0;

            // A single-cycle wait is covered by the RUN-state hazard; STALL holds the rest.
            if (flush) begin
                r_state     <= S_RUN;
                r_stall_cnt <= '0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_hazard && w_need_max > SEL_W'(1)) begin
                            r_state     <= S_STALL;
                            r_stall_cnt <= w_need_max - SEL_W'(1);
                        end
                    end
                    S_STALL: begin
                        r_stall_cnt <= r_stall_cnt - SEL_W'(1);
                        if (r_stall_cnt <= SEL_W'(1)) r_state <= S_RUN;
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

endmodule
